// File: rtl/accelerator_allocation_weighting_pkg.sv
// Shared types and fixed-point helpers for the DNC allocation weighting block.
// Holds the FSM state encoding, the zero word, the ONE constant and the
// truncating fixed-point multiply used by both the datapath and the buffer.
package accelerator_allocation_pkg;

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    INPUT_STATE   = 2'd1,
    OUTPUT_STATE  = 2'd2,
    ENDER_STATE   = 2'd3
  } state_t;

  localparam int PKG_DATA_SIZE = 64;
  localparam logic [PKG_DATA_SIZE-1:0] ZERO_DATA = '0;

  // Fixed-point representation of 1.0 for a given number of fraction bits.
  function automatic logic [PKG_DATA_SIZE-1:0] ONE_FIXED(input int unsigned frac);
    return 64'd1 << frac;
  endfunction

  // Full-width product, then keep bits [frac+63:frac]; plain truncation.
  function automatic logic [PKG_DATA_SIZE-1:0] fx_mul(input logic [PKG_DATA_SIZE-1:0] a,
                                                      input logic [PKG_DATA_SIZE-1:0] b,
                                                      input int unsigned frac);
    logic [2*PKG_DATA_SIZE-1:0] p;
    p = {64'd0, a} * {64'd0, b};
    p = p >> frac;
    return p[PKG_DATA_SIZE-1:0];
  endfunction

endpackage

// File: rtl/accelerator_allocation_weighting_if.sv
// Handshake/data bundle between the usage-sort stage, this block and the
// write-weighting stage. master = the side driving START/U_IN/PHI_IN,
// slave = the allocation weighting block itself.
interface accelerator_allocation_weighting_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic                 U_IN_ENABLE;
  logic                 A_OUT_ENABLE;
  logic [DATA_SIZE-1:0] SIZE_N_IN;
  logic [DATA_SIZE-1:0] U_IN;
  logic [DATA_SIZE-1:0] PHI_IN;
  logic [DATA_SIZE-1:0] A_OUT;
  logic [DATA_SIZE-1:0] A_INDEX_OUT;

  modport master (
    output START, U_IN_ENABLE, SIZE_N_IN, U_IN, PHI_IN,
    input  READY, A_OUT_ENABLE, A_OUT, A_INDEX_OUT
  );

  modport slave (
    input  START, U_IN_ENABLE, SIZE_N_IN, U_IN, PHI_IN,
    output READY, A_OUT_ENABLE, A_OUT, A_INDEX_OUT
  );
endinterface

// File: rtl/accelerator_allocation_weighting_buffer.sv
// Reorder buffer: DEPTH x DATA_SIZE simple dual-port RAM, one write port,
// one registered read port (latency 1), plus a per-entry valid vector that
// is cleared synchronously so unwritten entries read back as "not valid".
module accelerator_allocation_buffer #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 64,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DATA_SIZE-1:0] wr_dat_i,
  input  logic                 rd_en_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [DATA_SIZE-1:0] rd_dat_o,
  output logic                 rd_vld_o
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DATA_SIZE-1:0] rd_dat_q;
  logic                 rd_vld_q;

  // RAM write port; storage itself carries no reset, validity lives in valid_q.
  always_ff @(posedge CLK) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  // Valid bits: clear wins over a same-cycle write (they never coincide in use).
  always_ff @(posedge CLK) begin
    if (RST || clr_i) valid_q <= '0;
    else if (wr_en_i) valid_q[wr_addr_i] <= 1'b1;
  end

  // Registered read port; validity is sampled alongside the data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en_i & valid_q[rd_addr_i];
      if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;
  assign rd_vld_o = rd_vld_q;

endmodule

// File: rtl/accelerator_allocation_weighting.sv
// DNC allocation weighting a(j) = (1-u(j)) * prod_{i<j} u(i) over the sorted free list, one element per cycle.
// Define ACCELERATOR_ALLOCATION_REORDER_EN to reorder results into natural index order through a buffer;
// otherwise results stream in sorted order, one cycle after each accepted element.
module accelerator_allocation_weighting
  import accelerator_allocation_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int MAX_N         = 64
) (
  input  logic CLK,
  input  logic RST,
  accelerator_allocation_weighting_if.slave bus
);

  localparam int NW = $clog2(MAX_N + 1);
  localparam logic [DATA_SIZE-1:0] ONE     = ONE_FIXED(FRACTION_SIZE);
  localparam logic [DATA_SIZE-1:0] MAX_N_D = DATA_SIZE'(MAX_N);

  state_t               state_q;
  logic [NW-1:0]        n_q, count_q, n_d;
  logic [DATA_SIZE-1:0] prod_q, prod_d, uc_d, a_d;
  logic                 ready_q;
  logic                 last_in_d;

  // Clamp the requested length to what the block supports.
  always_comb begin
    n_d = bus.SIZE_N_IN[NW-1:0];
    if (bus.SIZE_N_IN > MAX_N_D) n_d = NW'(MAX_N);
  end

  // Weight and running product for the element on the bus; usage saturates at 1.0.
  always_comb begin
    uc_d   = (bus.U_IN > ONE) ? ONE : bus.U_IN;
    a_d    = fx_mul(ONE - uc_d, prod_q, FRACTION_SIZE);
    prod_d = fx_mul(prod_q, uc_d, FRACTION_SIZE);
  end

  assign last_in_d = (count_q + NW'(1)) == n_q;

`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
  localparam int AW = $clog2(MAX_N);

  logic [NW-1:0]        rd_cnt_q, idx_q;
  logic                 oe_q;
  logic                 wr_en, rd_en, clr;
  logic                 buf_vld;
  logic [DATA_SIZE-1:0] buf_dat;

  // Elements whose index falls outside the vector still advance prod/count but are not stored.
  assign wr_en = (state_q == INPUT_STATE) && bus.U_IN_ENABLE && (bus.PHI_IN < DATA_SIZE'(n_q));
  assign rd_en = (state_q == OUTPUT_STATE);
  assign clr   = (state_q == STARTER_STATE) && bus.START;

  accelerator_allocation_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (MAX_N),
    .AW        (AW)
  ) u_buffer (
    .CLK       (CLK),
    .RST       (RST),
    .clr_i     (clr),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.PHI_IN[AW-1:0]),
    .wr_dat_i  (a_d),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_cnt_q[AW-1:0]),
    .rd_dat_o  (buf_dat),
    .rd_vld_o  (buf_vld)
  );

  // Entries never written this operation read back as zero weight.
  assign bus.A_OUT        = buf_vld ? buf_dat : ZERO_DATA;
  assign bus.A_OUT_ENABLE = oe_q;
  assign bus.A_INDEX_OUT  = DATA_SIZE'(idx_q);
`else
  logic                 a_en_q;
  logic [DATA_SIZE-1:0] a_out_q, a_idx_q;

  assign bus.A_OUT        = a_out_q;
  assign bus.A_OUT_ENABLE = a_en_q;
  assign bus.A_INDEX_OUT  = a_idx_q;
`endif

  assign bus.READY = ready_q;

  // Control FSM with registered outputs; START/U_IN_ENABLE only act in their own states.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= STARTER_STATE;
      n_q      <= '0;
      count_q  <= '0;
      prod_q   <= ONE;
      ready_q  <= 1'b0;
`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
      rd_cnt_q <= '0;
      oe_q     <= 1'b0;
      idx_q    <= '0;
`else
      a_en_q   <= 1'b0;
      a_out_q  <= ZERO_DATA;
      a_idx_q  <= ZERO_DATA;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
      // Index/enable track the read issued one cycle earlier.
      oe_q  <= rd_en;
      idx_q <= rd_cnt_q;
`else
      a_en_q <= 1'b0;
`endif
      case (state_q)
        STARTER_STATE: begin
          if (bus.START) begin
            n_q     <= n_d;
            count_q <= '0;
            prod_q  <= ONE;
`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
            rd_cnt_q <= '0;
`endif
            state_q <= (n_d == '0) ? ENDER_STATE : INPUT_STATE;
          end
        end
        INPUT_STATE: begin
          if (bus.U_IN_ENABLE) begin
            prod_q  <= prod_d;
            count_q <= count_q + NW'(1);
`ifndef ACCELERATOR_ALLOCATION_REORDER_EN
            a_en_q  <= 1'b1;
            a_out_q <= a_d;
            a_idx_q <= bus.PHI_IN;
`endif
            if (last_in_d) begin
`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
              state_q  <= OUTPUT_STATE;
              rd_cnt_q <= '0;
`else
              state_q  <= ENDER_STATE;
`endif
            end
          end
        end
`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
        OUTPUT_STATE: begin
          if (rd_cnt_q == n_q - NW'(1)) state_q <= ENDER_STATE;
          else rd_cnt_q <= rd_cnt_q + NW'(1);
        end
`endif
        ENDER_STATE: begin
          ready_q <= 1'b1;
          state_q <= STARTER_STATE;
        end
        default: state_q <= STARTER_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_allocation_weighting.sv
// Directed bench for accelerator_allocation_weighting: expected (index, weight)
// pairs are queued when an operation starts and a monitor pops them whenever
// A_OUT_ENABLE is seen; READY must find the queue drained.
module tb_accelerator_allocation_weighting;

  localparam logic [63:0] ONE = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accelerator_allocation_weighting_if #(.DATA_SIZE(64)) bus ();

  accelerator_allocation_weighting #(
    .DATA_SIZE     (64),
    .FRACTION_SIZE (32),
    .MAX_N         (64)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];
  logic [63:0]  vec_u[8];
  logic [63:0]  vec_phi[8];
  logic [63:0]  vec_a[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic [63:0] u, input logic [63:0] phi, input logic [63:0] a);
    vec_u[k]   = u;
    vec_phi[k] = phi;
    vec_a[k]   = a;
  endtask

  // Expected output order depends on the build: sorted stream or natural index order.
  task automatic push_exp(input int n);
    for (int k = 0; k < n; k++) begin
`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
      logic [63:0] v;
      v = 64'd0;
      for (int j = 0; j < n; j++) if (vec_phi[j] == 64'(k)) v = vec_a[j];
      exp_q.push_back({64'(k), v});
`else
      exp_q.push_back({vec_phi[k], vec_a[k]});
`endif
    end
  endtask

  function automatic int exp_lat(input int n);
    if (n == 0) return 1;
`ifdef ACCELERATOR_ALLOCATION_REORDER_EN
    return 2 * n + 1;
`else
    return n + 1;
`endif
  endfunction

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    logic [127:0] e;
    if (bus.A_OUT_ENABLE === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got idx 0x%0h a 0x%0h, expected no output",
                 bus.A_INDEX_OUT, bus.A_OUT);
      end else begin
        e = exp_q.pop_front();
        check("a_index", bus.A_INDEX_OUT, e[127:64]);
        check("a_out", bus.A_OUT, e[63:0]);
      end
    end
    if (bus.READY === 1'b1) check("ready_drain", 64'(exp_q.size()), 64'd0);
  end

  // One operation: START, inputs following an enable pattern, then wait for READY.
  task automatic do_op(input string name, input int n, input int npat, input logic [15:0] pat,
                       input bit midstart, input bit chk_lat);
    int j;
    int lat;
    @(posedge clk); #1;
    bus.START     = 1'b1;
    bus.SIZE_N_IN = 64'(n);
    @(posedge clk); #1;
    bus.START     = 1'b0;
    bus.SIZE_N_IN = 64'hdead;
    push_exp(n);
    j = 0;
    for (int c = 0; c < npat; c++) begin
      if (pat[c]) begin
        bus.U_IN_ENABLE = 1'b1;
        bus.U_IN        = vec_u[j];
        bus.PHI_IN      = vec_phi[j];
        j++;
      end else begin
        bus.U_IN_ENABLE = 1'b0;
        bus.U_IN        = 64'h3;
        bus.PHI_IN      = 64'h7;
        if (midstart && c == 1) begin
          bus.START     = 1'b1;
          bus.SIZE_N_IN = 64'd1;
        end
      end
      @(posedge clk); #1;
      bus.START = 1'b0;
    end
    bus.U_IN_ENABLE = 1'b0;
    lat = npat;
    while (bus.READY !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.READY !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no READY after %0d cycles, expected READY", name, lat);
    end else if (chk_lat) begin
      check({name, "_latency"}, 64'(lat), 64'(exp_lat(n)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    bus.START       = 1'b0;
    bus.U_IN_ENABLE = 1'b0;
    bus.SIZE_N_IN   = '0;
    bus.U_IN        = '0;
    bus.PHI_IN      = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.READY), 64'd0);
    check("rst_a_en", 64'(bus.A_OUT_ENABLE), 64'd0);
    check("rst_a_out", bus.A_OUT, 64'd0);
    check("rst_a_idx", bus.A_INDEX_OUT, 64'd0);
    rst = 1'b0;

    // Basic sorted stream.
    set_vec(0, 64'h4000_0000, 64'd2, 64'hC000_0000);
    set_vec(1, 64'h8000_0000, 64'd0, 64'h2000_0000);
    set_vec(2, ONE,           64'd1, 64'h0);
    do_op("basic", 3, 3, 16'h7, 1'b0, 1'b1);

    // Saturation: usage above 1.0 clamps; prod stays 1.0 so saturated followers are 0 too.
    set_vec(0, 64'h2_0000_0000,         64'd0, 64'h0);
    set_vec(1, ONE,                     64'd1, 64'h0);
    set_vec(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0);
    do_op("sat", 3, 3, 16'h7, 1'b0, 1'b1);

    // Out-of-range index: element counts but is never stored.
    set_vec(0, 64'h4000_0000, 64'd5, 64'hC000_0000);
    set_vec(1, 64'h8000_0000, 64'd1, 64'h2000_0000);
    do_op("oor", 2, 2, 16'h3, 1'b0, 1'b1);

    // Empty vector.
    do_op("empty", 0, 0, 16'h0, 1'b0, 1'b1);

    // Stalled input with a stray START during a gap.
    set_vec(0, 64'h4000_0000, 64'd2, 64'hC000_0000);
    set_vec(1, 64'h8000_0000, 64'd0, 64'h2000_0000);
    set_vec(2, ONE,           64'd1, 64'h0);
    do_op("stall", 3, 5, 16'b11001, 1'b1, 1'b0);

    // Reset after 2 of 4 inputs.
    @(posedge clk); #1;
    bus.START     = 1'b1;
    bus.SIZE_N_IN = 64'd4;
    @(posedge clk); #1;
    bus.START     = 1'b0;
`ifndef ACCELERATOR_ALLOCATION_REORDER_EN
    exp_q.push_back({64'd3, 64'h8000_0000});
    exp_q.push_back({64'd2, 64'h4000_0000});
`endif
    bus.U_IN_ENABLE = 1'b1;
    bus.U_IN        = 64'h8000_0000;
    bus.PHI_IN      = 64'd3;
    @(posedge clk); #1;
    bus.PHI_IN      = 64'd2;
    @(posedge clk); #1;
    bus.U_IN_ENABLE = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_a_en", 64'(bus.A_OUT_ENABLE), 64'd0);
    check("midrst_a_out", bus.A_OUT, 64'd0);
    check("midrst_a_idx", bus.A_INDEX_OUT, 64'd0);
    check("midrst_ready", 64'(bus.READY), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.READY === 1'b1) seen++;
    end
    check("midrst_no_ready", 64'(seen), 64'd0);

    // Fresh operation after reset; indices 2 and 3 must not show the aborted writes.
    set_vec(0, 64'h4000_0000, 64'd0, 64'hC000_0000);
    set_vec(1, 64'h8000_0000, 64'd1, 64'h2000_0000);
    set_vec(2, ONE,           64'd0, 64'h0);
    set_vec(3, 64'h0,         64'd1, 64'h2000_0000);
    do_op("post_rst", 4, 4, 16'hF, 1'b0, 1'b1);

    // Back-to-back: second START in the cycle after READY, duplicate index, no stale entries.
    set_vec(0, 64'h4000_0000, 64'd0, 64'hC000_0000);
    set_vec(1, 64'h4000_0000, 64'd1, 64'h3000_0000);
    do_op("b2b_first", 2, 2, 16'h3, 1'b0, 1'b1);
    set_vec(0, 64'hC000_0000, 64'd1, 64'h4000_0000);
    set_vec(1, 64'h8000_0000, 64'd1, 64'h6000_0000);
    do_op("b2b_second", 2, 2, 16'h3, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("final_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
